// File: rtl/sbqm_pkg.sv
// Shared definitions for the SBqM teller dispatcher.
//   teller_state_t : per-teller lifecycle (IDLE -> CALL -> SERVE -> IDLE)
//   T_MAX          : number of physical tellers
//   HOLDOFF_CYC    : cycles after a grant during which no new grant issues
//   TICKET_WRAP_TO : ticket value issued after the all-ones ticket
//   sat_inc8       : saturating 8-bit increment used by the event counters
package sbqm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALL  = 2'd1,
    SERVE = 2'd2
  } teller_state_t;

  localparam int unsigned T_MAX          = 3;
  localparam int unsigned HOLDOFF_CYC    = 2;
  localparam int unsigned TICKET_WRAP_TO = 1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sbqm_rr_arb.sv
// Round-robin arbiter with one-hot grant and a last-grant pointer.
//   clk, rst   : clock, asynchronous active-low reset
//   req        : request vector, one bit per teller
//   en         : grants are only issued while en is high
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : index of the granted requester
//   gnt_valid  : a grant is issued this cycle
// Search starts at the index after the last grant; after reset the pointer
// sits at WIDTH-1 so requester 0 has top priority. Supports WIDTH <= 4.
module sbqm_rr_arb #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             en,
  output logic [WIDTH-1:0] gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_valid
);

  logic [1:0] last;
  logic [1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    if (en) begin
      for (int unsigned off = 1; off <= WIDTH; off++) begin
        cand = 2'((32'(last) + off) % WIDTH);
        if (!gnt_valid && req[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
          gnt[cand] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last <= 2'(WIDTH - 1);
    end else if (gnt_valid) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/sbqm_teller_dispatch.sv
// Teller-side dispatcher for the SBqM queue manager. Calls the next queued
// client to a free teller, pulses leave_n back into SBqM and tracks each
// teller through CALL / SERVE / no-show.
//   clk, rst        : clock, asynchronous active-low reset
//   pcount          : clients queued (from SBqM)
//   empty_flag      : SBqM empty flag
//   tcount          : enabled tellers (0..tcount-1)
//   client_arrived  : per-teller pulse, called client reached the counter
//   teller_done     : per-teller pulse, service finished
//   leave_n         : active-low one-cycle pulse to SBqM PhotocellLeave
//   call_valid      : one-cycle strobe for a new call
//   call_teller     : teller of the most recent call
//   call_ticket     : ticket of the most recent call (never 0 once issued)
//   teller_busy     : teller i in CALL or SERVE
//   no_show_count   : saturating count of timed-out calls
// Optional build macro SBQM_SVC_STATS_EN adds:
//   served_count    : saturating count of completed services
//   max_service     : longest SERVE duration in cycles (saturating)
module sbqm_teller_dispatch
  import sbqm_pkg::*;
#(
  parameter int unsigned N            = 3,
  parameter int unsigned T_MAX        = sbqm_pkg::T_MAX,
  parameter int unsigned CALL_TIMEOUT = 8,
  parameter int unsigned TICKET_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        pcount,
  input  logic                empty_flag,
  input  logic [1:0]          tcount,
  input  logic [T_MAX-1:0]    client_arrived,
  input  logic [T_MAX-1:0]    teller_done,
  output logic                leave_n,
  output logic                call_valid,
  output logic [1:0]          call_teller,
  output logic [TICKET_W-1:0] call_ticket,
  output logic [T_MAX-1:0]    teller_busy,
  output logic [7:0]          no_show_count
`ifdef SBQM_SVC_STATS_EN
  ,
  output logic [7:0]          served_count,
  output logic [7:0]          max_service
`endif
);

  localparam int unsigned TW = $clog2(CALL_TIMEOUT + 1);
  localparam int unsigned HW = $clog2(HOLDOFF_CYC + 1);

  teller_state_t     state    [T_MAX];
  teller_state_t     state_nx [T_MAX];
  logic [TW-1:0]     timer    [T_MAX];
  logic [TW-1:0]     timer_nx [T_MAX];
  logic [T_MAX-1:0]  req;
  logic [T_MAX-1:0]  gnt;
  logic [1:0]        gnt_idx;
  logic              gnt_valid;
  logic              grant_ok;
  logic [HW-1:0]     holdoff;
  logic [TICKET_W-1:0] next_ticket;
  logic [7:0]        nsc_nx;

  assign grant_ok = (pcount != '0) && !empty_flag && (holdoff == '0);

  always_comb begin
    req         = '0;
    teller_busy = '0;
    for (int unsigned i = 0; i < T_MAX; i++) begin
      req[i]         = (state[i] == IDLE) && (i < 32'(tcount));
      teller_busy[i] = (state[i] != IDLE);
    end
  end

  sbqm_rr_arb #(
    .WIDTH(T_MAX)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .en       (grant_ok),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );

  // The call window is CALL_TIMEOUT cycles: the cycle in which the timer
  // would reach 0 is the last chance to arrive, and arrival wins over it.
  always_comb begin
    nsc_nx = no_show_count;
    for (int unsigned i = 0; i < T_MAX; i++) begin
      state_nx[i] = state[i];
      timer_nx[i] = timer[i];
      case (state[i])
        IDLE: begin
          if (gnt[i]) begin
            state_nx[i] = CALL;
            timer_nx[i] = TW'(CALL_TIMEOUT);
          end
        end
        CALL: begin
          if (client_arrived[i]) begin
            state_nx[i] = SERVE;
          end else if (timer[i] <= TW'(1)) begin
            state_nx[i] = IDLE;
            timer_nx[i] = '0;
            nsc_nx      = sat_inc8(nsc_nx);
          end else begin
            timer_nx[i] = timer[i] - TW'(1);
          end
        end
        SERVE: begin
          if (teller_done[i]) state_nx[i] = IDLE;
        end
        default: state_nx[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < T_MAX; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < T_MAX; i++) begin
        state[i] <= state_nx[i];
        timer[i] <= timer_nx[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      leave_n       <= 1'b1;
      call_valid    <= 1'b0;
      call_teller   <= '0;
      call_ticket   <= '0;
      next_ticket   <= TICKET_W'(TICKET_WRAP_TO);
      holdoff       <= '0;
      no_show_count <= '0;
    end else begin
      leave_n       <= !gnt_valid;
      call_valid    <= gnt_valid;
      no_show_count <= nsc_nx;
      if (gnt_valid) begin
        call_teller <= gnt_idx;
        call_ticket <= next_ticket;
        next_ticket <= (next_ticket == '1) ? TICKET_W'(TICKET_WRAP_TO)
                                           : next_ticket + TICKET_W'(1);
        holdoff     <= HW'(HOLDOFF_CYC);
      end else if (holdoff != '0) begin
        holdoff <= holdoff - HW'(1);
      end
    end
  end

`ifdef SBQM_SVC_STATS_EN
  // svc_cyc counts SERVE cycles already elapsed, so the duration reported
  // on the done cycle is svc_cyc + 1.
  logic [7:0]       svc_cyc [T_MAX];
  logic [T_MAX-1:0] done_evt;
  logic [7:0]       served_nx;
  logic [7:0]       max_nx;
  logic [7:0]       dur;

  always_comb begin
    served_nx = served_count;
    max_nx    = max_service;
    dur       = '0;
    done_evt  = '0;
    for (int unsigned i = 0; i < T_MAX; i++) begin
      done_evt[i] = (state[i] == SERVE) && teller_done[i];
      dur         = sat_inc8(svc_cyc[i]);
      if (done_evt[i]) begin
        served_nx = sat_inc8(served_nx);
        if (dur > max_nx) max_nx = dur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      served_count <= '0;
      max_service  <= '0;
      for (int unsigned i = 0; i < T_MAX; i++) svc_cyc[i] <= '0;
    end else begin
      served_count <= served_nx;
      max_service  <= max_nx;
      for (int unsigned i = 0; i < T_MAX; i++) begin
        svc_cyc[i] <= ((state[i] == SERVE) && !done_evt[i]) ? sat_inc8(svc_cyc[i]) : '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sbqm_teller_dispatch.sv
// Directed self-checking bench for sbqm_teller_dispatch. Inputs are driven
// and outputs sampled on the falling edge; "step s" is the s-th falling edge
// after reset release. Stats ports are checked when SBQM_SVC_STATS_EN is set.
module tb_sbqm_teller_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] pcount = '0;
  logic       empty_flag = 1'b1;
  logic [1:0] tcount = '0;
  logic [2:0] client_arrived = '0;
  logic [2:0] teller_done = '0;
  logic       leave_n;
  logic       call_valid;
  logic [1:0] call_teller;
  logic [7:0] call_ticket;
  logic [2:0] teller_busy;
  logic [7:0] no_show_count;
`ifdef SBQM_SVC_STATS_EN
  logic [7:0] served_count;
  logic [7:0] max_service;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbqm_teller_dispatch #(
    .N(3),
    .T_MAX(3),
    .CALL_TIMEOUT(8),
    .TICKET_W(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pcount        (pcount),
    .empty_flag    (empty_flag),
    .tcount        (tcount),
    .client_arrived(client_arrived),
    .teller_done   (teller_done),
    .leave_n       (leave_n),
    .call_valid    (call_valid),
    .call_teller   (call_teller),
    .call_ticket   (call_ticket),
    .teller_busy   (teller_busy),
    .no_show_count (no_show_count)
`ifdef SBQM_SVC_STATS_EN
    ,
    .served_count  (served_count),
    .max_service   (max_service)
`endif
  );

  task automatic init_and_reset(input logic [2:0] pc, input logic ef, input logic [1:0] tc);
    rst = 1'b0;
    pcount = pc;
    empty_flag = ef;
    tcount = tc;
    client_arrived = '0;
    teller_done = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_cv;
    rst = 1'b0;
    pcount = 3'd3;
    empty_flag = 1'b0;
    tcount = 2'd1;
    client_arrived = '0;
    teller_done = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({leave_n, call_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_strobes: leave_n,call_valid=%b want 10", {leave_n, call_valid});
    end
    checks++;
    if (call_teller !== 2'd0 || call_ticket !== 8'd0) begin
      errors++; $display("FAIL reset_call: teller=%0d ticket=%0d want 0 0", call_teller, call_ticket);
    end
    checks++;
    if (teller_busy !== 3'b000 || no_show_count !== 8'd0) begin
      errors++; $display("FAIL reset_state: busy=%b noshow=%0d want 000 0", teller_busy, no_show_count);
    end
    rst = 1'b1;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      exp_cv = (s == 1 || s == 10);
      checks++;
      if (call_valid !== exp_cv || leave_n !== !exp_cv) begin
        errors++; $display("FAIL reset_pulse step %0d: call_valid=%b leave_n=%b want %b %b",
                           s, call_valid, leave_n, exp_cv, !exp_cv);
      end
      if (s == 1) begin
        checks++;
        if (call_teller !== 2'd0 || call_ticket !== 8'd1 || teller_busy !== 3'b001) begin
          errors++; $display("FAIL first_call: teller=%0d ticket=%0d busy=%b want 0 1 001",
                             call_teller, call_ticket, teller_busy);
        end
      end
      if (s == 9) begin
        checks++;
        if (no_show_count !== 8'd1 || teller_busy !== 3'b000) begin
          errors++; $display("FAIL timeout_single: noshow=%0d busy=%b want 1 000", no_show_count, teller_busy);
        end
      end
      if (s == 10) begin
        checks++;
        if (call_teller !== 2'd0 || call_ticket !== 8'd2) begin
          errors++; $display("FAIL recall: teller=%0d ticket=%0d want 0 2", call_teller, call_ticket);
        end
      end
    end
  endtask

  task automatic test_round_robin_noshow();
    logic       exp_cv;
    logic [1:0] exp_tel;
    logic [7:0] exp_tkt;
    init_and_reset(3'd5, 1'b0, 2'd3);
    for (int s = 1; s <= 13; s++) begin
      @(negedge clk);
      exp_cv = (s == 1 || s == 4 || s == 7 || s == 13);
      checks++;
      if (call_valid !== exp_cv || leave_n !== !exp_cv) begin
        errors++; $display("FAIL rr_strobe step %0d: call_valid=%b leave_n=%b want %b %b",
                           s, call_valid, leave_n, exp_cv, !exp_cv);
      end
      if (exp_cv) begin
        case (s)
          1:       begin exp_tel = 2'd0; exp_tkt = 8'd1; end
          4:       begin exp_tel = 2'd1; exp_tkt = 8'd2; end
          7:       begin exp_tel = 2'd2; exp_tkt = 8'd3; end
          default: begin exp_tel = 2'd1; exp_tkt = 8'd4; end
        endcase
        checks++;
        if (call_teller !== exp_tel || call_ticket !== exp_tkt) begin
          errors++; $display("FAIL rr_call step %0d: teller=%0d ticket=%0d want %0d %0d",
                             s, call_teller, call_ticket, exp_tel, exp_tkt);
        end
      end
      if (s == 7) begin
        checks++;
        if (teller_busy !== 3'b111) begin
          errors++; $display("FAIL rr_busy_all: busy=%b want 111", teller_busy);
        end
      end
      if (s == 12) begin
        checks++;
        if (teller_busy !== 3'b101 || no_show_count !== 8'd1) begin
          errors++; $display("FAIL noshow_t1: busy=%b noshow=%0d want 101 1", teller_busy, no_show_count);
        end
      end
      client_arrived = (s == 2) ? 3'b001 : (s == 8) ? 3'b100 : 3'b000;
    end
    client_arrived = '0;
  endtask

  task automatic test_arrive_at_timeout();
    init_and_reset(3'd2, 1'b0, 2'd1);
    for (int s = 1; s <= 13; s++) begin
      @(negedge clk);
      if (s == 1) begin
        checks++;
        if (call_valid !== 1'b1 || call_ticket !== 8'd1) begin
          errors++; $display("FAIL tmo_call: call_valid=%b ticket=%0d want 1 1", call_valid, call_ticket);
        end
      end
      if (s == 4) begin
        checks++;
        if (teller_busy !== 3'b001) begin
          errors++; $display("FAIL done_ignored_in_call: busy=%b want 001", teller_busy);
        end
      end
      if (s == 9) begin
        checks++;
        if (teller_busy !== 3'b001 || no_show_count !== 8'd0 || call_valid !== 1'b0) begin
          errors++; $display("FAIL arrive_wins: busy=%b noshow=%0d call_valid=%b want 001 0 0",
                             teller_busy, no_show_count, call_valid);
        end
      end
      if (s == 12) begin
        checks++;
        if (teller_busy !== 3'b000) begin
          errors++; $display("FAIL serve_done: busy=%b want 000", teller_busy);
        end
      end
      if (s == 13) begin
        checks++;
        if (call_valid !== 1'b1 || call_ticket !== 8'd2 || call_teller !== 2'd0) begin
          errors++; $display("FAIL call_after_serve: call_valid=%b ticket=%0d teller=%0d want 1 2 0",
                             call_valid, call_ticket, call_teller);
        end
      end
      client_arrived = (s == 8) ? 3'b001 : 3'b000;
      teller_done    = (s == 3 || s == 11) ? 3'b001 : 3'b000;
    end
    client_arrived = '0;
    teller_done = '0;
  endtask

  task automatic test_no_grant_conditions();
    logic [2:0] pc_tab [4] = '{3'd0, 3'd2, 3'd0, 3'd3};
    logic       ef_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] tc_tab [4] = '{2'd3, 2'd3, 2'd3, 2'd0};
    init_and_reset(3'd0, 1'b1, 2'd3);
    for (int p = 0; p < 4; p++) begin
      pcount = pc_tab[p];
      empty_flag = ef_tab[p];
      tcount = tc_tab[p];
      for (int s = 1; s <= 5; s++) begin
        @(negedge clk);
        checks++;
        if (call_valid !== 1'b0 || leave_n !== 1'b1) begin
          errors++; $display("FAIL no_grant phase %0d step %0d: call_valid=%b leave_n=%b want 0 1",
                             p, s, call_valid, leave_n);
        end
      end
    end
    tcount = 2'd2;
    @(negedge clk);
    checks++;
    if (call_valid !== 1'b1 || call_teller !== 2'd0 || call_ticket !== 8'd1) begin
      errors++; $display("FAIL enable_call: call_valid=%b teller=%0d ticket=%0d want 1 0 1",
                         call_valid, call_teller, call_ticket);
    end
  endtask

  task automatic test_ticket_wrap();
    int         n = 0;
    int         last_s = 0;
    logic [7:0] exp_t = 8'd1;
    init_and_reset(3'd5, 1'b0, 2'd3);
    client_arrived = '1;
    teller_done = '1;
    for (int s = 1; s <= 1000 && n < 257; s++) begin
      @(negedge clk);
      if (call_valid === 1'b1) begin
        n++;
        checks++;
        if (call_ticket !== exp_t || call_teller !== 2'((n - 1) % 3)) begin
          errors++; $display("FAIL wrap_call %0d: ticket=%0d teller=%0d want %0d %0d",
                             n, call_ticket, call_teller, exp_t, (n - 1) % 3);
        end
        if (n > 1) begin
          checks++;
          if (s - last_s != 3) begin
            errors++; $display("FAIL wrap_spacing %0d: gap=%0d want 3", n, s - last_s);
          end
        end
        last_s = s;
        exp_t = (exp_t == 8'd255) ? 8'd1 : exp_t + 8'd1;
      end
    end
    checks++;
    if (n != 257) begin
      errors++; $display("FAIL wrap_budget: calls=%0d want 257", n);
    end
    checks++;
    if (no_show_count !== 8'd0) begin
      errors++; $display("FAIL wrap_noshow: noshow=%0d want 0", no_show_count);
    end
    client_arrived = '0;
    teller_done = '0;
  endtask

  task automatic test_reset_mid_serve();
    init_and_reset(3'd3, 1'b0, 2'd1);
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
`ifdef SBQM_SVC_STATS_EN
      if (s == 6) begin
        checks++;
        if (served_count !== 8'd1 || max_service !== 8'd3) begin
          errors++; $display("FAIL stats: served=%0d max=%0d want 1 3", served_count, max_service);
        end
      end
`endif
      if (s == 7) begin
        checks++;
        if (call_valid !== 1'b1 || call_ticket !== 8'd2) begin
          errors++; $display("FAIL second_call: call_valid=%b ticket=%0d want 1 2", call_valid, call_ticket);
        end
      end
      if (s == 10) begin
        checks++;
        if (teller_busy !== 3'b001) begin
          errors++; $display("FAIL pre_reset_serve: busy=%b want 001", teller_busy);
        end
      end
      client_arrived = (s == 2 || s == 8) ? 3'b001 : 3'b000;
      teller_done    = (s == 5) ? 3'b001 : 3'b000;
    end
    client_arrived = '0;
    teller_done = '0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (leave_n !== 1'b1 || call_valid !== 1'b0 || call_teller !== 2'd0 || call_ticket !== 8'd0 ||
        teller_busy !== 3'b000 || no_show_count !== 8'd0) begin
      errors++; $display("FAIL async_reset: leave_n=%b cv=%b teller=%0d ticket=%0d busy=%b noshow=%0d want 1 0 0 0 000 0",
                         leave_n, call_valid, call_teller, call_ticket, teller_busy, no_show_count);
    end
`ifdef SBQM_SVC_STATS_EN
    checks++;
    if (served_count !== 8'd0 || max_service !== 8'd0) begin
      errors++; $display("FAIL async_reset_stats: served=%0d max=%0d want 0 0", served_count, max_service);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (call_valid !== 1'b1 || call_ticket !== 8'd1 || call_teller !== 2'd0) begin
      errors++; $display("FAIL post_reset_call: call_valid=%b ticket=%0d teller=%0d want 1 1 0",
                         call_valid, call_ticket, call_teller);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin_noshow();
    test_arrive_at_timeout();
    test_no_grant_conditions();
    test_ticket_wrap();
    test_reset_mid_serve();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/sbqm_teller_dispatch.md
Name: sbqm_teller_dispatch

Overview:
Teller-side companion to the SBqM queue manager. It consumes the queue occupancy and decides when the next client is called to a free teller. For each call it drives the active-low PhotocellLeave-equivalent pulse back into SBqM, presents a ticket/teller call for the display, and tracks each teller through call, service and no-show.

Parameters:
N, 3, width of pcount; must match SBqM n.
T_MAX, 3, number of physical tellers; the tcount range is 0..3.
CALL_TIMEOUT, 8, cycles a called client has to reach the teller before being declared a no-show.
TICKET_W, 8, width of the ticket number.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
pcount  in  N  clients currently queued, from SBqM.
empty_flag  in  1  SBqM empty flag.
tcount  in  2  enabled tellers; tellers 0..tcount-1 are enabled.
client_arrived  in  T_MAX  one-cycle pulse per teller: called client reached the counter.
teller_done  in  T_MAX  one-cycle pulse per teller: service finished.
leave_n  out  1  active-low one-cycle pulse to SBqM PhotocellLeave.
call_valid  out  1  one-cycle strobe: a new call is issued.
call_teller  out  2  teller index of the current call.
call_ticket  out  TICKET_W  ticket number of the current call.
teller_busy  out  T_MAX  bit i is high while teller i is in CALL or SERVE.
no_show_count  out  8  saturating count of timed-out calls.

Behaviour:
- Reset (rst=0, asynchronous):
  - every teller goes to IDLE; leave_n=1; call_valid=0; call_teller=0.
  - call_ticket=0; no_show_count=0; teller_busy=0; the next ticket issued is 1.
- Per-teller FSM, states IDLE, CALL, SERVE:
  - IDLE: the teller requests a client when it is enabled (i<tcount).
  - IDLE->CALL: on an arbiter grant. The call timer loads CALL_TIMEOUT.
  - CALL->SERVE: on client_arrived[i].
  - CALL->IDLE: when the timer reaches 0 without arrival; no_show_count increments, saturating at 255.
  - Arrival and timeout in the same cycle: arrival wins and the FSM goes to SERVE.
  - SERVE->IDLE: on teller_done[i].
  - Ignored pulses: teller_done outside SERVE, and client_arrived outside CALL.
- Grant condition: a grant issues only when pcount!=0, empty_flag=0 and the dispatcher is not in holdoff.
  - At most one grant per cycle.
  - Round-robin order among requesting tellers, starting after the last granted index. After reset, teller 0 has top priority.
- Grant cycle, registered so outputs are visible in the following cycle:
  - leave_n=0 for exactly 1 cycle.
  - call_valid=1 for 1 cycle.
  - call_teller and call_ticket update and then hold until the next call.
  - The ticket increments; after 2^TICKET_W-1 it wraps to 1, so 0 is never issued.
- Holdoff: after each grant no new grant is issued for 2 cycles. This lets SBqM register the leave and update pcount, so one queued client is never called twice.
- Reducing tcount: a teller already in CALL or SERVE finishes normally. It just makes no new request once it is back in IDLE.
- tcount=0: no calls are issued; leave_n stays 1.

Optional Feature:
SBQM_SVC_STATS_EN:
- Defined: adds output served_count[7:0], which increments on every SERVE->IDLE transition and saturates at 255. Also adds output max_service[7:0], the longest SERVE duration in cycles (saturating). Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package sbqm_pkg holds:
  - the teller state enum {IDLE, CALL, SERVE};
  - constant T_MAX=3 and HOLDOFF_CYC=2;
  - the ticket wrap value.
- One sub-module, sbqm_rr_arb: a T_MAX-wide round-robin arbiter with a one-hot grant and a last-grant pointer. It is instantiated once.

Test Plan:
- Reset with pcount=3, tcount=1 -> after rst releases, leave_n pulses low for 1 cycle; call_teller=0 and call_ticket=1. No second call while teller 0 is busy.
- tcount=3, pcount=5, all tellers idle -> calls go to tellers 0, 1, 2 with tickets 1, 2, 3, spaced 3 cycles apart; teller_busy=3'b111.
- Teller 1 is called and no client_arrived follows for 8 cycles -> teller 1 returns to IDLE; no_show_count=1; with pcount still >0, the next grant goes to teller 1 (round-robin).
- client_arrived coinciding with the timeout cycle -> teller enters SERVE; no_show_count unchanged; teller_done later returns it to IDLE.
- pcount=0 with empty_flag=1 and all tellers idle -> leave_n stays 1 and call_valid stays 0. A ticket counter preloaded to 255 wraps to 1 on the next call.
- rst asserted while a teller is in SERVE with SBQM_SVC_STATS_EN defined -> all outputs reset immediately, including served_count=0 and max_service=0; the first post-reset call has ticket 1.
